// File: rtl/request_handler_pkg.sv
// Shared types and constants for the two-byte request-frame decoder.
package request_handler_pkg;

   localparam int unsigned DATA_W              = 8;
   localparam int unsigned SEL_W               = 32;
   localparam int unsigned STATE_W             = 3;
   localparam int unsigned DEFAULT_NUM_DEVICES = 32;

   // Request code that is reserved and never accepted.
   localparam logic [DATA_W-1:0] REQ_NONE = 8'h00;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE         = 3'd0,
      ST_WAIT_ADDRESS = 3'd1,
      ST_VALIDATE     = 3'd2,
      ST_ISSUE        = 3'd3,
      ST_DISCARD      = 3'd4
   } state_e;

   // A frame is publishable when the code is not reserved and the address is in range.
   function automatic logic frame_ok(input logic [DATA_W-1:0] req,
                                     input logic [DATA_W-1:0] addr,
                                     input int unsigned       num_devices);
      return (req != REQ_NONE) && (32'(addr) < num_devices);
   endfunction

endpackage

// File: rtl/request_handler.sv
// Two-byte request-frame decoder: request code then device address, published on a valid frame.
module request_handler
   import request_handler_pkg::*;
#(
   parameter int unsigned NUM_DEVICES = DEFAULT_NUM_DEVICES
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                enable,
   input  logic [DATA_W-1:0]   received_data,
   output logic                has_request,
   output logic [DATA_W-1:0]   request,
   output logic                device_selected,
   output logic [SEL_W-1:0]    device_selector,
   output logic [STATE_W-1:0]  debug_state
);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   req_byte_q, req_byte_d;
   logic [DATA_W-1:0]   addr_byte_q, addr_byte_d;
   logic [DATA_W-1:0]   request_q, request_d;
   logic [SEL_W-1:0]    device_selector_q, device_selector_d;
   logic                device_selected_q, device_selected_d;
   logic                has_request_q, has_request_d;

   // State and output registers; reset discards any partial frame.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q           <= ST_IDLE;
         req_byte_q        <= '0;
         addr_byte_q       <= '0;
         request_q         <= '0;
         device_selector_q <= '0;
         device_selected_q <= 1'b0;
         has_request_q     <= 1'b0;
      end else begin
         state_q           <= state_d;
         req_byte_q        <= req_byte_d;
         addr_byte_q       <= addr_byte_d;
         request_q         <= request_d;
         device_selector_q <= device_selector_d;
         device_selected_q <= device_selected_d;
         has_request_q     <= has_request_d;
      end
   end

   // Next-state and output-register load logic; published values hold unless a frame validates.
   always_comb begin
      state_d           = state_q;
      req_byte_d        = req_byte_q;
      addr_byte_d       = addr_byte_q;
      request_d         = request_q;
      device_selector_d = device_selector_q;
      device_selected_d = device_selected_q;
      has_request_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               req_byte_d = received_data;
               state_d    = ST_WAIT_ADDRESS;
            end
         end
         ST_WAIT_ADDRESS: begin
            if (enable) begin
               addr_byte_d = received_data;
               state_d     = ST_VALIDATE;
            end
         end
         ST_VALIDATE: begin
            if (frame_ok(req_byte_q, addr_byte_q, NUM_DEVICES)) begin
               request_d         = req_byte_q;
               device_selector_d = SEL_W'(addr_byte_q);
               device_selected_d = 1'b1;
               has_request_d     = 1'b1;
               state_d           = ST_ISSUE;
            end else begin
               state_d = ST_DISCARD;
            end
         end
         ST_ISSUE:   state_d = ST_IDLE;
         ST_DISCARD: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   assign has_request     = has_request_q;
   assign request         = request_q;
   assign device_selected = device_selected_q;
   assign device_selector = device_selector_q;
   assign debug_state     = state_q;

endmodule

// File: tb/tb_request_handler.sv
// Self-checking bench for request_handler: directed vector table plus randomized model comparison.
module tb_request_handler;

   logic        clock;
   logic        reset_n;
   logic        enable;
   logic [7:0]  received_data;
   logic        has_request;
   logic [7:0]  request;
   logic        device_selected;
   logic [31:0] device_selector;
   logic [2:0]  debug_state;

   int checks;
   int errors;

   request_handler dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .enable          (enable),
      .received_data   (received_data),
      .has_request     (has_request),
      .request         (request),
      .device_selected (device_selected),
      .device_selector (device_selector),
      .debug_state     (debug_state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Directed vector record: inputs for one edge and expected outputs after it.
   typedef struct {
      logic        en;
      logic [7:0]  data;
      logic [2:0]  st;
      logic        has;
      logic [7:0]  req;
      logic [31:0] sel;
      logic        dsel;
   } vec_t;

   vec_t vecs[$];

   // Reference model: bytes of the frame being assembled, plus post-frame dead cycles.
   logic [7:0]  mq[$];
   int          post;
   bit          last_ok;
   logic [7:0]  m_req;
   logic [31:0] m_sel;
   logic        m_dsel;
   logic        m_has;

   function automatic void model_reset();
      mq.delete();
      post    = 0;
      last_ok = 0;
      m_req   = 8'h00;
      m_sel   = 32'd0;
      m_dsel  = 1'b0;
      m_has   = 1'b0;
   endfunction

   function automatic void model_edge(input logic en, input logic [7:0] d);
      m_has = 1'b0;
      if (post == 2) begin
         last_ok = (mq[0] != 8'h00) && (int'(mq[1]) < 32);
         if (last_ok) begin
            m_req  = mq[0];
            m_sel  = 32'(mq[1]);
            m_dsel = 1'b1;
            m_has  = 1'b1;
         end
         mq.delete();
         post = 1;
      end else if (post == 1) begin
         post = 0;
      end else if (en) begin
         mq.push_back(d);
         if (mq.size() == 2) post = 2;
      end
   endfunction

   function automatic logic [2:0] model_state();
      if (post == 2) return 3'd2;
      if (post == 1) return last_ok ? 3'd3 : 3'd4;
      return (mq.size() == 1) ? 3'd1 : 3'd0;
   endfunction

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void check_all(input string tag, input logic [2:0] st, input logic has,
                                     input logic [7:0] req, input logic [31:0] sel, input logic dsel);
      check({tag, ".state"},  32'(debug_state),     32'(st));
      check({tag, ".has"},    32'(has_request),     32'(has));
      check({tag, ".req"},    32'(request),         32'(req));
      check({tag, ".sel"},    device_selector,      sel);
      check({tag, ".dsel"},   32'(device_selected), 32'(dsel));
   endfunction

   // Drive one byte slot on the falling edge, advance the model at the rising edge, settle.
   task automatic step(input logic en, input logic [7:0] d);
      @(negedge clock);
      enable        = en;
      received_data = d;
      @(posedge clock);
      model_edge(en, d);
      #1;
   endtask

   // Asynchronous reset pulse between edges; outputs must clear without a clock edge.
   task automatic async_reset(input string tag);
      #2;
      enable  = 1'b0;
      reset_n = 1'b0;
      #1;
      check_all(tag, 3'd0, 1'b0, 8'h00, 32'd0, 1'b0);
      model_reset();
      reset_n = 1'b1;
   endtask

   function automatic void add(input logic en, input logic [7:0] d, input logic [2:0] st,
                               input logic has, input logic [7:0] req, input logic [31:0] sel,
                               input logic dsel);
      vec_t v;
      v.en = en; v.data = d; v.st = st; v.has = has; v.req = req; v.sel = sel; v.dsel = dsel;
      vecs.push_back(v);
   endfunction

   initial begin
      checks        = 0;
      errors        = 0;
      reset_n       = 1'b0;
      enable        = 1'b0;
      received_data = 8'h00;
      model_reset();

      #12;
      check_all("reset", 3'd0, 1'b0, 8'h00, 32'd0, 1'b0);
      #1;
      reset_n = 1'b1;

      // Out-of-range address, then enable held high for six more bytes of 8'h20.
      add(1, 8'hFF, 1, 0, 8'h00, 32'd0, 0);
      add(1, 8'h20, 2, 0, 8'h00, 32'd0, 0);
      add(1, 8'h20, 4, 0, 8'h00, 32'd0, 0);
      add(1, 8'h20, 0, 0, 8'h00, 32'd0, 0);
      add(1, 8'h20, 1, 0, 8'h00, 32'd0, 0);
      add(1, 8'h20, 2, 0, 8'h00, 32'd0, 0);
      add(1, 8'h20, 4, 0, 8'h00, 32'd0, 0);
      add(1, 8'h20, 0, 0, 8'h00, 32'd0, 0);
      add(0, 8'h00, 0, 0, 8'h00, 32'd0, 0);
      // Valid frame 01/05.
      add(1, 8'h01, 1, 0, 8'h00, 32'd0, 0);
      add(1, 8'h05, 2, 0, 8'h00, 32'd0, 0);
      add(0, 8'h00, 3, 1, 8'h01, 32'd5, 1);
      add(0, 8'h00, 0, 0, 8'h01, 32'd5, 1);
      // Reserved request code keeps the previous frame.
      add(1, 8'h00, 1, 0, 8'h01, 32'd5, 1);
      add(1, 8'h03, 2, 0, 8'h01, 32'd5, 1);
      add(0, 8'h00, 4, 0, 8'h01, 32'd5, 1);
      add(0, 8'h00, 0, 0, 8'h01, 32'd5, 1);
      // Gapped bytes, last valid address 31.
      add(1, 8'h10, 1, 0, 8'h01, 32'd5, 1);
      for (int i = 0; i < 4; i++) add(0, 8'h00, 1, 0, 8'h01, 32'd5, 1);
      add(1, 8'h1F, 2, 0, 8'h01, 32'd5, 1);
      add(0, 8'h00, 3, 1, 8'h10, 32'd31, 1);
      add(0, 8'h00, 0, 0, 8'h10, 32'd31, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].en, vecs[i].data);
         check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].has, vecs[i].req,
                   vecs[i].sel, vecs[i].dsel);
      end

      // Reset mid-frame: the byte after reset starts a new frame.
      step(1, 8'h02);
      check("midrst.pre_state", 32'(debug_state), 32'd1);
      async_reset("midrst.async");
      step(1, 8'h07);
      check_all("midrst.new_req", 3'd1, 1'b0, 8'h00, 32'd0, 1'b0);
      step(0, 8'h00);
      check_all("midrst.hold", 3'd1, 1'b0, 8'h00, 32'd0, 1'b0);
      step(1, 8'h03);
      step(0, 8'h00);
      check_all("midrst.issue", 3'd3, 1'b1, 8'h07, 32'd3, 1'b1);
      step(0, 8'h00);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 3000; i++) begin
         logic       en;
         logic [7:0] d;
         en = ($urandom_range(0, 3) != 0);
         d  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
         step(en, d);
         check_all($sformatf("rand%0d", i), model_state(), m_has, m_req, m_sel, m_dsel);
         if ($urandom_range(0, 299) == 0) async_reset($sformatf("rand_rst%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
